// File: rtl/apb2axi_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : apb2axi_apb_initiator
// Description : Burst-command to APB initiator. It accepts one read or write
//               burst of 1..16 beats and runs one APB transfer per beat.
//               Addresses step by 4 and wrap at 2^APB_ADDR_W. It returns one
//               response per beat, and PSLVERR does not abort the burst.
// Options     : APB_INITIATOR_TIMEOUT_EN - when defined, an ACCESS phase that
//               waits TIMEOUT_CYC cycles without PREADY is abandoned and the
//               beat is reported as an error.
// Revision    : 1.0 - initial release
// ============================================================================
module apb2axi_apb_initiator #(
  parameter int APB_ADDR_W  = 32,
  parameter int APB_DATA_W  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [3:0]            cmd_len,
  // write data channel
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [APB_DATA_W-1:0] wd_data,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_last,
  // APB initiator port
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] len;
  logic [3:0] beat;
  logic       last_beat;
  logic       tmo_hit;

  assign last_beat = (beat == len);

`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Fires on the ACCESS cycle that would make TIMEOUT_CYC cycles without PREADY
  assign tmo_hit = (state == S_ACCESS) && !PREADY &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Wait counter: cleared in SETUP so each ACCESS phase starts from zero
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tmo_cnt <= '0;
    end else if (state == S_SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == S_ACCESS) && !PREADY) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived handshake/APB control outputs
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wd_ready   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_last   = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    case (state)
      S_IDLE: begin
        // Held low while reset is applied so nothing is taken during reset
        cmd_ready = PRESETn;
        if (cmd_valid) begin
          state_next = cmd_write ? S_WDATA : S_SETUP;
        end
      end
      S_WDATA: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        PSEL       = 1'b1;
        state_next = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || tmo_hit) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_last  = last_beat;
        if (rsp_ready) begin
          if (last_beat) begin
            state_next = S_IDLE;
          end else begin
            state_next = PWRITE ? S_WDATA : S_SETUP;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Command, APB address/data and response capture
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      len       <= '0;
      beat      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            len    <= cmd_len;
            beat   <= '0;
          end
        end
        S_WDATA: begin
          if (wd_valid) begin
            PWDATA <= wd_data;
          end
        end
        S_ACCESS: begin
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
          end else if (tmo_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        S_RESP: begin
          // Full-width increment; the low two address bits are carried as given
          if (rsp_ready && !last_beat) begin
            PADDR <= PADDR + APB_ADDR_W'(4);
            beat  <= beat + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb2axi_apb_initiator
// Description : Directed self-checking bench for apb2axi_apb_initiator with a
//               small APB completer (programmable wait states, error address,
//               address-derived read data) that logs each SETUP phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb2axi_apb_initiator;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wd_valid;
  logic        wd_ready;
  logic [31:0] wd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb2axi_apb_initiator #(
    .APB_ADDR_W (32),
    .APB_DATA_W (32),
    .TIMEOUT_CYC(8)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .wd_data  (wd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .rsp_last (rsp_last),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  int checks = 0;
  int passes = 0;

  // completer configuration and logs
  int          wait_cfg = 0;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          acc_k    = 0;
  int          apb_unstable = 0;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] setup_addr[$];
  logic [31:0] setup_wdata[$];
  logic        setup_write[$];
  int          acc_len[$];

  // per-command results
  logic [31:0] wr_words[16];
  logic [31:0] rsp_rdata_q[$];
  logic        rsp_err_q[$];
  logic        rsp_last_q[$];
  int          hold_psel;
  int          rsp_unstable;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish, got stuck, required completion");
    $fatal(1, "global timeout");
  end

  // Completer: decides PREADY for the posedge ending the current ACCESS cycle
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      setup_addr.push_back(PADDR);
      setup_wdata.push_back(PWDATA);
      setup_write.push_back(PWRITE);
      cur_addr  = PADDR;
      cur_wdata = PWDATA;
      acc_k     = 0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      PRDATA    = 32'h0;
    end else if (PSEL && PENABLE) begin
      acc_k = acc_k + 1;
      if (PADDR !== cur_addr || PWDATA !== cur_wdata) apb_unstable++;
      PREADY  = (acc_k > wait_cfg);
      PSLVERR = PREADY && err_en && (PADDR == err_addr);
      PRDATA  = PREADY ? (PADDR ^ 32'hCAFEF10D) : 32'h0;
      if (PREADY) acc_len.push_back(acc_k);
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = 32'h0;
    end
  end

  task automatic clear_logs();
    setup_addr.delete();
    setup_wdata.delete();
    setup_write.delete();
    acc_len.delete();
    apb_unstable = 0;
  endtask

  task automatic bound_fail(input string what);
    $display("FAIL %s bound expired, waited too long, required handshake", what);
    checks++;
  endtask

  // Drives one burst and collects every beat's response
  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [3:0] l,
                         input int wd_delay, input int rsp_delay);
    int n;
    logic [31:0] s_rd;
    logic        s_er;
    logic        s_la;
    rsp_rdata_q.delete();
    rsp_err_q.delete();
    rsp_last_q.delete();
    hold_psel    = 0;
    rsp_unstable = 0;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge PCLK); n++; end
    if (!cmd_ready) begin cmd_valid = 1'b0; bound_fail("cmd_ready"); return; end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    for (int b = 0; b <= int'(l); b++) begin
      if (wr) begin
        for (int d = 0; d < wd_delay; d++) begin
          @(negedge PCLK);
          if (PSEL) hold_psel++;
        end
        wd_data  = wr_words[b];
        wd_valid = 1'b1;
        n = 0;
        while (!wd_ready && n < 50) begin @(negedge PCLK); n++; end
        if (!wd_ready) begin wd_valid = 1'b0; bound_fail("wd_ready"); return; end
        @(negedge PCLK);
        wd_valid = 1'b0;
      end
      n = 0;
      while (!rsp_valid && n < 2000) begin @(negedge PCLK); n++; end
      if (!rsp_valid) begin bound_fail("rsp_valid"); return; end
      s_rd = rsp_rdata;
      s_er = rsp_err;
      s_la = rsp_last;
      for (int d = 0; d < rsp_delay; d++) begin
        @(negedge PCLK);
        if (PSEL) hold_psel++;
        if (!rsp_valid || rsp_rdata !== s_rd || rsp_err !== s_er || rsp_last !== s_la)
          rsp_unstable++;
      end
      rsp_rdata_q.push_back(s_rd);
      rsp_err_q.push_back(s_er);
      rsp_last_q.push_back(s_la);
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({cmd_ready, wd_ready, rsp_valid, PSEL, PENABLE, PWRITE} !== 6'b0)
      $display("FAIL reset_ctrl got %b required 000000",
               {cmd_ready, wd_ready, rsp_valid, PSEL, PENABLE, PWRITE});
    else passes++;
    checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== 96'h0 || rsp_err !== 1'b0 || rsp_last !== 1'b0)
      $display("FAIL reset_data got %h/%h/%h/%b/%b required zeros",
               PADDR, PWDATA, rsp_rdata, rsp_err, rsp_last);
    else passes++;
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release cmd_ready got %b required 1", cmd_ready);
    else passes++;
  endtask

  task automatic test_single_read();
    clear_logs();
    wait_cfg = 0;
    run_cmd(1'b0, 32'h100, 4'd0, 0, 0);
    checks++;
    if (setup_addr.size() != 1 || acc_len.size() != 1 || acc_len[0] != 1)
      $display("FAIL read_phases got setups=%0d access=%0d required 1 and 1",
               setup_addr.size(), (acc_len.size() > 0) ? acc_len[0] : -1);
    else passes++;
    checks++;
    if (rsp_rdata_q[0] !== 32'hCAFEF00D || rsp_last_q[0] !== 1'b1 || rsp_err_q[0] !== 1'b0)
      $display("FAIL read_rsp got %h last=%b err=%b required cafef00d last=1 err=0",
               rsp_rdata_q[0], rsp_last_q[0], rsp_err_q[0]);
    else passes++;
    checks++;
    if (setup_write[0] !== 1'b0 || setup_addr[0] !== 32'h100)
      $display("FAIL read_apb got addr=%h write=%b required 00000100 0", setup_addr[0], setup_write[0]);
    else passes++;
  endtask

  task automatic test_write_burst();
    logic [31:0] exp_a[4];
    logic [31:0] exp_d[4];
    exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) wr_words[i] = exp_d[i];
    clear_logs();
    run_cmd(1'b1, 32'h1000, 4'd3, 0, 0);
    checks++;
    if (setup_addr.size() != 4) $display("FAIL wr_beats got %0d required 4", setup_addr.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (setup_addr[i] !== exp_a[i] || setup_wdata[i] !== exp_d[i] || setup_write[i] !== 1'b1)
        $display("FAIL wr_beat%0d got %h/%h/%b required %h/%h/1", i,
                 setup_addr[i], setup_wdata[i], setup_write[i], exp_a[i], exp_d[i]);
      else passes++;
      checks++;
      if (rsp_last_q[i] !== (i == 3) || rsp_rdata_q[i] !== 32'h0 || rsp_err_q[i] !== 1'b0)
        $display("FAIL wr_rsp%0d got last=%b rdata=%h err=%b required last=%0d rdata=0 err=0",
                 i, rsp_last_q[i], rsp_rdata_q[i], rsp_err_q[i], (i == 3));
      else passes++;
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    run_cmd(1'b0, 32'hFFFFFFFC, 4'd1, 0, 0);
    checks++;
    if (setup_addr[0] !== 32'hFFFFFFFC || setup_addr[1] !== 32'h00000000)
      $display("FAIL wrap_addr got %h,%h required fffffffc,00000000", setup_addr[0], setup_addr[1]);
    else passes++;
    checks++;
    if (rsp_rdata_q[0] !== 32'h35010EF1 || rsp_rdata_q[1] !== 32'hCAFEF10D ||
        rsp_last_q[0] !== 1'b0 || rsp_last_q[1] !== 1'b1)
      $display("FAIL wrap_rsp got %h,%h last=%b%b required 35010ef1,cafef10d last=01",
               rsp_rdata_q[0], rsp_rdata_q[1], rsp_last_q[0], rsp_last_q[1]);
    else passes++;
  endtask

  task automatic test_wait_err();
    clear_logs();
    wait_cfg = 5;
    err_en   = 1'b1;
    err_addr = 32'h200;
    run_cmd(1'b0, 32'h200, 4'd1, 0, 0);
    wait_cfg = 0;
    err_en   = 1'b0;
    checks++;
    if (acc_len.size() != 2 || acc_len[0] != 6 || acc_len[1] != 6 || apb_unstable != 0)
      $display("FAIL wait_access got n=%0d len0=%0d unstable=%0d required 2 6 0",
               acc_len.size(), (acc_len.size() > 0) ? acc_len[0] : -1, apb_unstable);
    else passes++;
    checks++;
    if (rsp_err_q[0] !== 1'b1 || rsp_err_q[1] !== 1'b0 || rsp_last_q[1] !== 1'b1)
      $display("FAIL wait_err got err=%b%b last1=%b required err=10 last1=1",
               rsp_err_q[0], rsp_err_q[1], rsp_last_q[1]);
    else passes++;
    checks++;
    if (setup_addr[1] !== 32'h204) $display("FAIL wait_beat1 got %h required 00000204", setup_addr[1]);
    else passes++;
  endtask

  task automatic test_backpressure();
    wr_words[0] = 32'hA5A5_0001;
    wr_words[1] = 32'h5A5A_0002;
    clear_logs();
    run_cmd(1'b1, 32'h302, 4'd1, 7, 10);
    checks++;
    if (hold_psel != 0 || rsp_unstable != 0)
      $display("FAIL bp_hold got psel_cycles=%0d unstable=%0d required 0 0", hold_psel, rsp_unstable);
    else passes++;
    checks++;
    if (setup_addr.size() != 2 || setup_addr[0] !== 32'h302 || setup_addr[1] !== 32'h306 ||
        setup_wdata[0] !== 32'hA5A50001 || setup_wdata[1] !== 32'h5A5A0002)
      $display("FAIL bp_apb got n=%0d %h/%h %h/%h required 302/a5a50001 306/5a5a0002",
               setup_addr.size(), setup_addr[0], setup_wdata[0], setup_addr[1], setup_wdata[1]);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    wait_cfg  = 20;
    cmd_write = 1'b0;
    cmd_addr  = 32'h500;
    cmd_len   = 4'd2;
    cmd_valid = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    n = 0;
    while (!PENABLE && n < 20) begin @(negedge PCLK); n++; end
    checks++;
    if (!PENABLE) $display("FAIL rstmid_access got PENABLE=0 required 1");
    else passes++;
    PRESETn = 1'b0;
    @(negedge PCLK);
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL rstmid_drop got psel=%b penable=%b rsp_valid=%b required 000", PSEL, PENABLE, rsp_valid);
    else passes++;
    @(negedge PCLK);
    PRESETn  = 1'b1;
    wait_cfg = 0;
    seen = 0;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) seen++;
    end
    checks++;
    if (seen != 0 || cmd_ready !== 1'b1)
      $display("FAIL rstmid_idle got activity=%0d cmd_ready=%b required 0 1", seen, cmd_ready);
    else passes++;
    clear_logs();
    run_cmd(1'b0, 32'h100, 4'd0, 0, 0);
    checks++;
    if (rsp_rdata_q[0] !== 32'hCAFEF00D || rsp_last_q[0] !== 1'b1)
      $display("FAIL rstmid_after got %h last=%b required cafef00d 1", rsp_rdata_q[0], rsp_last_q[0]);
    else passes++;
  endtask

`ifdef APB_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    wait_cfg = 1000;
    run_cmd(1'b0, 32'h400, 4'd0, 0, 0);
    wait_cfg = 0;
    checks++;
    if (acc_k != 8 || acc_len.size() != 0)
      $display("FAIL tmo_cycles got %0d ready=%0d required 8 0", acc_k, acc_len.size());
    else passes++;
    checks++;
    if (rsp_err_q[0] !== 1'b1 || rsp_rdata_q[0] !== 32'h0 || rsp_last_q[0] !== 1'b1)
      $display("FAIL tmo_rsp got err=%b rdata=%h last=%b required 1 0 1",
               rsp_err_q[0], rsp_rdata_q[0], rsp_last_q[0]);
    else passes++;
  endtask
`endif

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_len   = 4'd0;
    wd_valid  = 1'b0;
    wd_data   = 32'h0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = 32'h0;
    for (int i = 0; i < 16; i++) wr_words[i] = 32'h0;
    test_reset();
    test_single_read();
    test_write_burst();
    test_wrap();
    test_wait_err();
    test_backpressure();
    test_reset_mid();
`ifdef APB_INITIATOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
